// File: rtl/ext_pkg.sv
// Shared definitions for the registered immediate/load extender.
// Build option EXT_LOAD_EN widens the mode field and adds byte/half load modes.
package ext_pkg;

`ifdef EXT_LOAD_EN
    localparam int unsigned EXT_MODE_W = 3;
`else
    localparam int unsigned EXT_MODE_W = 2;
`endif

    typedef logic [EXT_MODE_W-1:0] ext_mode_t;

    localparam ext_mode_t  EXT_ZERO = EXT_MODE_W'(0);
    localparam ext_mode_t  EXT_SIGN = EXT_MODE_W'(1);
    localparam ext_mode_t  EXT_HIGH = EXT_MODE_W'(2);
    localparam ext_mode_t  EXT_BR   = EXT_MODE_W'(3);
    localparam logic [2:0] EXT_LB   = 3'd4;
    localparam logic [2:0] EXT_LBU  = 3'd5;
    localparam logic [2:0] EXT_LH   = 3'd6;
    localparam logic [2:0] EXT_LHU  = 3'd7;

    // Encoded as {main_valid, skid_valid}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } ext_state_t;

endpackage

// File: rtl/ext_if.sv
// Upstream/downstream handshake bundle of the extender pipe.
// Build option EXT_LOAD_EN adds in_boff.
interface ext_if
    import ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    ext_mode_t        in_mode;
`ifdef EXT_LOAD_EN
    logic [1:0]       in_boff;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_imm, in_mode,
`ifdef EXT_LOAD_EN
        output in_boff,
`endif
        input  in_ready,
        input  out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  in_valid, in_imm, in_mode,
`ifdef EXT_LOAD_EN
        input  in_boff,
`endif
        output in_ready,
        output out_valid, out_data,
        input  out_ready
    );
endinterface

// File: rtl/ext_core.sv
// Combinational extension mode mux.
// Build option EXT_LOAD_EN adds byte/half load selection via boff.
module ext_core
    import ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  ext_mode_t        mode,
`ifdef EXT_LOAD_EN
    input  logic [1:0]       boff,
`endif
    output logic [OUT_W-1:0] ext_c
);

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;

    // Casts rather than replication so IN_W == OUT_W stays legal
    assign zext = OUT_W'(imm);
    assign sext = OUT_W'($signed(imm));

`ifdef EXT_LOAD_EN
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = imm[{boff, 3'b000} +: 8];
    assign half_sel = imm[{boff[1], 4'b0000} +: 16];
`endif

    always_comb begin
        ext_c = zext;
        case (mode)
            EXT_ZERO: ext_c = zext;
            EXT_SIGN: ext_c = sext;
            EXT_HIGH: ext_c = zext << (OUT_W - IN_W);
            EXT_BR:   ext_c = sext << 2;
`ifdef EXT_LOAD_EN
            EXT_LB:   ext_c = OUT_W'($signed(byte_sel));
            EXT_LBU:  ext_c = OUT_W'(byte_sel);
            EXT_LH:   ext_c = OUT_W'($signed(half_sel));
            EXT_LHU:  ext_c = OUT_W'(half_sel);
`endif
            default:  ext_c = zext;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Registered immediate extender with a 2-entry skid buffer and flush.
// Build option EXT_LOAD_EN enables load-extension modes (requires IN_W == OUT_W >= 32).
module ext_pipe
    import ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    ext_if.slave bus
);

`ifdef EXT_LOAD_EN
    if (IN_W != OUT_W || OUT_W < 32) begin : g_bad_param
        $error("ext_pipe: EXT_LOAD_EN requires IN_W == OUT_W >= 32");
    end
`else
    if (IN_W < 2 || IN_W + 2 > OUT_W) begin : g_bad_param
        $error("ext_pipe: requires 2 <= IN_W <= OUT_W-2");
    end
`endif

    ext_state_t       state_q, state_nxt;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] main_q;
    logic [OUT_W-1:0] skid_q;
    logic [OUT_W-1:0] ext_c;
    logic             acc, xfer;
    logic             load_main, load_skid, main_from_skid;

    ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .imm   (bus.in_imm),
        .mode  (bus.in_mode),
`ifdef EXT_LOAD_EN
        .boff  (bus.in_boff),
`endif
        .ext_c (ext_c)
    );

    assign acc  = bus.in_valid && in_ready_q;
    assign xfer = out_valid_q && bus.out_ready;

    // Next state and data-path enables; flush overrides everything
    always_comb begin
        state_nxt      = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        load_main = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && xfer) begin
                        load_main = 1'b1;
                    end else if (acc) begin
                        load_skid = 1'b1;
                        state_nxt = ST_FULL;
                    end else if (xfer) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (xfer) begin
                        main_from_skid = 1'b1;
                        state_nxt      = ST_ONE;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            in_ready_q  <= (state_nxt != ST_FULL);
            out_valid_q <= (state_nxt != ST_EMPTY);
        end
    end

    // Data registers are left untouched by flush; only validity is squashed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= ext_c;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= ext_c;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;

endmodule
